// File: rtl/cache_pkg.sv
// cache_pkg: shared geometry, FSM state type and address-split helpers for the cache fill path.
package cache_pkg;
    localparam int ADDR_W     = 16;
    localparam int SETS       = 128;
    localparam int WORDS      = 8;
    localparam int TAG_W      = 5;
    localparam int IDX_W      = 7;
    localparam int OFF_W      = 3;
    localparam int META_W     = 8;
    localparam int META_VALID = 7;

    typedef enum logic {IDLE, FILL} state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[OFF_W+1 +: IDX_W];
    endfunction

    function automatic logic [OFF_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
        return a[1 +: OFF_W];
    endfunction
endpackage

// File: rtl/onehot_dec.sv
// onehot_dec: binary to one-hot decoder with enable; all-zero output when disabled.
module onehot_dec #(
    parameter int N = 3
) (
    input  logic              en,
    input  logic [N-1:0]      sel,
    output logic [2**N-1:0]   onehot
);
    assign onehot = en ? {{(2**N-1){1'b0}}, 1'b1} << sel : '0;
endmodule

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: on a miss, issues 8 word reads to memory and steers returned words into the cache arrays.
module cache_fill_ctrl
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              memory_data_valid,
    input  logic [15:0]       memory_data,
    output logic              fsm_busy,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              data_write,
    output logic              tag_write,
    output logic [SETS-1:0]   block_enable,
    output logic [WORDS-1:0]  word_enable,
    output logic [15:0]       data_out,
    output logic [META_W-1:0] meta_out,
    output logic              fill_done
);
    state_t           state, state_n;
    logic [TAG_W-1:0] tag_q;
    logic [IDX_W-1:0] idx_q;
    logic [3:0]       issue_cnt, recv_cnt;
    logic             last;
    logic             unused_bits;

    // The fill always starts at word 0, so the offset bits of the miss address are not needed.
    assign unused_bits = ^miss_address[OFF_W:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tag_q     <= '0;
            idx_q     <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && miss_detected) begin
                tag_q     <= addr_tag(miss_address);
                idx_q     <= addr_index(miss_address);
                issue_cnt <= '0;
                recv_cnt  <= '0;
            end else if (state == FILL) begin
                if (!issue_cnt[3]) issue_cnt <= issue_cnt + 4'd1;
                if (memory_data_valid) recv_cnt <= recv_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        fsm_busy   = state == FILL;
        mem_read   = fsm_busy && !issue_cnt[3];
        mem_addr   = mem_read ? {tag_q, idx_q, issue_cnt[OFF_W-1:0], 1'b0} : '0;
        data_write = fsm_busy && memory_data_valid;
        last       = data_write && recv_cnt == 4'd7;
        tag_write  = last;
        fill_done  = last;
        data_out   = data_write ? memory_data : '0;
        meta_out   = last ? {1'b1, 2'b00, tag_q} : '0;
        state_n    = state == IDLE ? (miss_detected ? FILL : IDLE) : (last ? IDLE : FILL);
    end

    // Every strobe cycle (including the tag write) coincides with a data write.
    onehot_dec #(.N(IDX_W)) u_block_dec (
        .en     (data_write),
        .sel    (idx_q),
        .onehot (block_enable)
    );

    onehot_dec #(.N(OFF_W)) u_word_dec (
        .en     (data_write),
        .sel    (recv_cnt[OFF_W-1:0]),
        .onehot (word_enable)
    );
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl: directed and randomized fills checked against a transaction-level fill model.
`timescale 1ns/1ps
module tb_cache_fill_ctrl;
    logic         clk = 0;
    logic         rst;
    logic         miss_detected;
    logic [15:0]  miss_address;
    logic         memory_data_valid;
    logic [15:0]  memory_data;
    logic         fsm_busy, mem_read, data_write, tag_write, fill_done;
    logic [15:0]  mem_addr, data_out;
    logic [127:0] block_enable;
    logic [7:0]   word_enable, meta_out;

    cache_fill_ctrl dut (
        .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
        .memory_data_valid(memory_data_valid), .memory_data(memory_data),
        .fsm_busy(fsm_busy), .mem_read(mem_read), .mem_addr(mem_addr),
        .data_write(data_write), .tag_write(tag_write), .block_enable(block_enable),
        .word_enable(word_enable), .data_out(data_out), .meta_out(meta_out), .fill_done(fill_done)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int now = 0;
    // Reference model: one outstanding fill described by its block base address,
    // cycles elapsed since the fill began and words delivered so far.
    bit          m_busy = 0;
    logic [15:0] m_base = 0;
    int          m_cyc = 0, m_recv = 0;
    // Pipelined memory: responses queued in request order with their due cycle.
    int          due_q[$];
    logic [15:0] dat_q[$];
    logic [15:0] salt = 0;
    int          dw_cnt, tw_cnt, fd_cnt, fd_cyc;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, now);
        end
    endtask

    task automatic cycle(input bit r, input bit miss, input logic [15:0] a, input int lat, input int gap);
        bit          v, e_rd, e_dw, e_last;
        logic [15:0] d;
        v = 0;
        d = 16'hFFFF ^ salt;
        if (due_q.size() > 0 && due_q[0] <= now && $urandom_range(0, 99) >= gap) begin
            v = 1;
            d = dat_q[0];
            void'(due_q.pop_front());
            void'(dat_q.pop_front());
        end else if (!m_busy) begin
            v = $urandom_range(0, 1);
        end
        rst = r; miss_detected = miss; miss_address = a;
        memory_data_valid = v; memory_data = d;
        #1;
        e_rd   = m_busy && m_cyc < 8;
        e_dw   = m_busy && v;
        e_last = e_dw && m_recv == 7;
        chk("fsm_busy", fsm_busy, m_busy);
        chk("mem_read", mem_read, e_rd);
        chk("mem_addr", mem_addr, e_rd ? m_base + 16'(2 * m_cyc) : 16'h0);
        chk("data_write", data_write, e_dw);
        chk("tag_write", tag_write, e_last);
        chk("fill_done", fill_done, e_last);
        chk("block_enable", block_enable, e_dw ? 128'b1 << m_base[10:4] : 128'b0);
        chk("word_enable", word_enable, e_dw ? 8'b1 << m_recv : 8'b0);
        chk("data_out", data_out, e_dw ? d : 16'h0);
        chk("meta_out", meta_out, e_last ? {3'b100, m_base[15:11]} : 8'h0);
        dw_cnt += int'(data_write);
        tw_cnt += int'(tag_write);
        if (fill_done) begin fd_cnt++; fd_cyc = now; end
        if (e_rd && !r) begin
            due_q.push_back(now + lat);
            dat_q.push_back(16'h1000 + 16'(m_cyc) + salt);
        end
        @(posedge clk);
        if (r) begin
            m_busy = 0; m_cyc = 0; m_recv = 0;
            due_q.delete(); dat_q.delete();
        end else if (!m_busy) begin
            if (miss) begin m_busy = 1; m_base = {a[15:4], 4'h0}; m_cyc = 0; m_recv = 0; end
        end else begin
            if (m_cyc < 8) m_cyc++;
            if (v) begin
                if (m_recv == 7) m_busy = 0;
                else m_recv++;
            end
        end
        now++;
        @(negedge clk);
    endtask

    // Runs one fill from IDLE; optional spurious miss mid-fill, reset at a given cycle, random misses.
    task automatic fill(input logic [15:0] a, input int lat, input int gap, input int rst_at,
                        input logic [15:0] a2, input int rmiss);
        int k, start;
        k = 0;
        start = now;
        dw_cnt = 0; tw_cnt = 0; fd_cnt = 0; fd_cyc = -1;
        cycle(0, 1, a, lat, gap);
        do begin
            k++;
            if (k == rst_at) cycle(1, 0, a, lat, gap);
            else if (k == 3 && a2 != 16'h0) cycle(0, 1, a2, lat, gap);
            else cycle(0, $urandom_range(0, 99) < rmiss, 16'($urandom), lat, gap);
        end while (m_busy && k < 80);
        chk("fill_timeout", m_busy, 0);
        fd_cyc = fd_cyc >= 0 ? fd_cyc - start : -1;
    endtask

    initial begin
        rst = 1; miss_detected = 0; miss_address = 0; memory_data_valid = 0; memory_data = 0;
        @(negedge clk);
        cycle(1, 0, 16'h0, 4, 0);
        cycle(1, 0, 16'h0, 4, 0);
        dw_cnt = 0; tw_cnt = 0;
        repeat (4) cycle(0, 0, 16'h0, 4, 0);
        chk("idle_no_writes", dw_cnt + tw_cnt, 0);

        fill(16'hA5B6, 4, 0, -1, 16'h0010, 0);
        chk("a5b6_writes", dw_cnt, 8);
        chk("a5b6_done_cnt", fd_cnt, 1);
        chk("a5b6_done_cycle", fd_cyc, 12);
        cycle(0, 0, 16'h0, 4, 0);

        fill(16'h3C48, 4, 0, 7, 16'h0, 0);
        chk("rst_no_tag", tw_cnt, 0);
        cycle(0, 0, 16'h0, 4, 0);
        fill(16'h3C48, 2, 0, -1, 16'h0, 0);
        chk("restart_writes", dw_cnt, 8);
        chk("restart_done", fd_cnt, 1);

        salt = 16'h0200;
        fill(16'h7FFE, 1, 50, -1, 16'h0, 0);
        chk("gap_writes", dw_cnt, 8);
        chk("gap_done", fd_cnt, 1);

        for (int i = 0; i < 40; i++) begin
            salt = 16'($urandom);
            fill(16'($urandom), $urandom_range(1, 6), $urandom_range(0, 60),
                 ($urandom_range(0, 9) == 0) ? $urandom_range(1, 14) : -1,
                 16'h0, 30);
            repeat ($urandom_range(0, 2)) cycle(0, 0, 16'h0, 4, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_fill_ctrl.md
Name: cache_fill_ctrl

Overview:
Miss-handling controller for the direct-mapped cache: 128 blocks × 8 words × 16 bit, with an 8-bit metadata entry per block.
- On a miss it issues 8 sequential word reads to pipelined main memory.
- It steers each returned word into the data array using one-hot block/word enables.
- It writes the new tag/valid metadata with the final word.
- It sits between the pipeline's hit/miss logic and the cache + memory ports; one instance per cache (I and D).

Parameters:
ADDR_W, 16, byte-address width
SETS, 128, number of blocks (index width = log2(SETS) = 7)
WORDS, 8, 16-bit words per block (offset = 4 byte bits)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
miss_detected  in  1  cache miss on miss_address this cycle
miss_address  in  16  byte address of the missing access
memory_data_valid  in  1  memory_data carries the next returned word
memory_data  in  16  word returned by memory, in request order
fsm_busy  out  1  fill in progress; pipeline stalls
mem_read  out  1  memory read request this cycle
mem_addr  out  16  word-aligned request address
data_write  out  1  write strobe to data array
tag_write  out  1  write strobe to metadata array
block_enable  out  128  one-hot block select for both arrays
word_enable  out  8  one-hot word select for data array
data_out  out  16  word to data array (= memory_data)
meta_out  out  8  metadata {valid=1, 2'b00, tag[4:0]}
fill_done  out  1  one-cycle pulse with the final word

Behaviour:
Address split:
- tag = addr[15:11]
- index = addr[10:4]
- word = addr[3:1]
- addr[0] ignored

States:
- IDLE: all outputs 0. miss_detected=1 → latch tag/index, clear issue_cnt and recv_cnt, go to FILL next cycle.
- FILL:
  - fsm_busy=1.
  - mem_read=1 while issue_cnt<8, with mem_addr={tag,index,issue_cnt,1'b0}; issue_cnt increments each cycle until it reaches 8. One request per cycle, no backpressure.
  - When memory_data_valid=1: data_write=1, word_enable=onehot(recv_cnt), block_enable=onehot(index), data_out=memory_data, and recv_cnt increments.
  - On recv_cnt==7 with memory_data_valid=1: tag_write=1, meta_out={1'b1,2'b00,tag}, fill_done=1, all in the same cycle; go to IDLE.

Output rules:
- block_enable is nonzero only when data_write or tag_write is 1.
- meta_out is 0 when tag_write=0.
- data_out is 0 when data_write=0.
- Strobe outputs are combinational from state, counters and memory_data_valid. State and counters are registered.

Latency: miss in cycle 0 → first request in cycle 1, last request in cycle 8. With a 4-cycle memory, data arrives in cycles 5–12 and fsm_busy falls in cycle 13.

Boundaries:
- miss_detected while busy: ignored; the latched address is unchanged.
- memory_data_valid in IDLE: ignored, no strobes.
- Data may return before all 8 requests have issued; issue and receive counters run independently.
- miss_detected in the cycle that returns to IDLE: ignored. The pipeline re-presents it next cycle as a hit or a new miss.
- rst at any time, including mid-fill: next cycle is IDLE, counters 0, all outputs 0. Partially written words stay; the tag is not written, so the block remains invalid/stale.
- Counters are 4 bits, so issue_cnt saturates at 8 and never wraps.

Decomposition:
- Shared package cache_pkg: ADDR_W, SETS, WORDS, TAG_W=5, IDX_W=7, OFF_W=3, state enum {IDLE, FILL}, META_VALID bit position, address-split helper functions.
- One sub-module, onehot_dec (N-bit binary → 2^N one-hot, with enable). Instantiated for block_enable (7→128) and word_enable (3→8).

Test Plan:
- Reset, then idle with memory_data_valid=1, memory_data=16'hFFFF → all outputs 0; no data_write or tag_write.
- miss_detected=1, miss_address=16'hA5B6 → cycles 1–8: mem_addr = 16'hA5B0, A5B2 … A5BE.
- Same fill, memory returns 16'h1000+i for i=0..7 at cycles 5–12 → data_write each cycle; word_enable=8'h01…8'h80; block_enable bit 7'h5B set. Cycle 12: tag_write=1, meta_out=8'h94, fill_done=1. Cycle 13: fsm_busy=0.
- Second miss_detected (16'h0010) during fill → ignored; all mem_addr values keep tag/index of 16'hA5B6.
- rst asserted in cycle 7 of a fill → cycle 8: IDLE, outputs 0, tag_write never asserted. A following miss restarts at word 0.
- Memory with valid gaps (valid every other cycle) → exactly 8 data_writes in order; fill_done only with the 8th word.
